// File: rtl/aq_spsram_arb_256x59.sv
// Round-robin read/write arbiter and pin sequencer for a 256x59 single-port SRAM.
// Define AQ_SPSRAM_ARB_INIT_EN to add the post-reset / on-demand array clear.
module aq_spsram_arb_256x59 (
    input  logic        forever_cpuclk,
    input  logic        cpurst_b,
    input  logic        inv_req,
    output logic        inv_done,
    output logic        busy,
    input  logic        rd_req,
    input  logic [7:0]  rd_addr,
    output logic        rd_gnt,
    output logic        rd_data_vld,
    output logic [58:0] rd_data,
    input  logic        wr_req,
    input  logic [7:0]  wr_addr,
    input  logic [58:0] wr_data,
    input  logic [58:0] wr_mask,
    output logic        wr_gnt,
    output logic [7:0]  sram_a,
    output logic        sram_cen,
    output logic        sram_gwen,
    output logic [58:0] sram_wen,
    output logic [58:0] sram_d,
    input  logic [58:0] sram_q
);

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    // state_q is the observation point for the sequencer state.
    state_t      state_q;
    logic        inv_eff;
    logic        clr_wr;
    logic [7:0]  clr_idx;
    logic        arb_en;
    logic        prio_q;
    logic        prio_d;
    logic        rd_pend_q;

`ifdef AQ_SPSRAM_ARB_INIT_EN
    state_t      state_d;
    logic [7:0]  cnt_q;
    logic [7:0]  cnt_d;
    logic        inv_done_q;

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_q    <= ST_INIT;
            cnt_q      <= 8'd0;
            inv_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            inv_done_q <= (state_q == ST_INIT) && (cnt_q == 8'hFF);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_INIT: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == 8'hFF) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                if (inv_req) begin
                    state_d = ST_INIT;
                    cnt_d   = 8'd0;
                end
            end
            default: state_d = ST_READY;
        endcase
    end

    assign busy     = (state_q == ST_INIT);
    assign inv_done = inv_done_q;
    assign clr_wr   = (state_q == ST_INIT);
    assign clr_idx  = cnt_q;
    assign inv_eff  = inv_req;
`else
    logic unused_inv_req;

    assign unused_inv_req = inv_req;
    assign state_q        = ST_READY;
    assign busy           = 1'b0;
    assign inv_done       = 1'b0;
    assign clr_wr         = 1'b0;
    assign clr_idx        = 8'd0;
    assign inv_eff        = 1'b0;
`endif

    // req/gnt handshake: a requester raises req with addr/data stable and keeps them
    // until it sees gnt; the cycle gnt is high is the transfer. Dropping req early is legal.
    assign arb_en = cpurst_b && (state_q == ST_READY) && !inv_eff;
    assign rd_gnt = arb_en && rd_req && (!wr_req || !prio_q);
    assign wr_gnt = arb_en && wr_req && (!rd_req || prio_q);

    // On contention the winner hands priority to the loser.
    always_comb begin
        prio_d = prio_q;
        if (arb_en && rd_req && wr_req) begin
            prio_d = ~prio_q;
        end
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

    // Pins are registered: the access granted in cycle T appears on the macro in T+1.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            sram_a    <= 8'd0;
            sram_cen  <= 1'b1;
            sram_gwen <= 1'b1;
            sram_wen  <= '1;
            sram_d    <= '0;
        end else if (clr_wr) begin
            sram_a    <= clr_idx;
            sram_cen  <= 1'b0;
            sram_gwen <= 1'b0;
            sram_wen  <= '0;
            sram_d    <= '0;
        end else if (rd_gnt) begin
            sram_a    <= rd_addr;
            sram_cen  <= 1'b0;
            sram_gwen <= 1'b1;
            sram_wen  <= '1;
        end else if (wr_gnt) begin
            sram_a    <= wr_addr;
            sram_cen  <= 1'b0;
            sram_gwen <= 1'b0;
            sram_wen  <= ~wr_mask;
            sram_d    <= wr_data;
        end else begin
            sram_cen  <= 1'b1;
            sram_gwen <= 1'b1;
            sram_wen  <= '1;
        end
    end

    // Two stages: pin cycle, then macro output cycle.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            rd_pend_q   <= 1'b0;
            rd_data_vld <= 1'b0;
        end else begin
            rd_pend_q   <= rd_gnt;
            rd_data_vld <= rd_pend_q;
        end
    end

    assign rd_data = sram_q;

    assert property (@(posedge forever_cpuclk) disable iff (!cpurst_b) !(rd_gnt && wr_gnt));
    assert property (@(posedge forever_cpuclk) disable iff (!cpurst_b) busy |-> !(rd_gnt || wr_gnt));

endmodule
